// File: rtl/rmii_tx_framer.sv
// RMII transmit framer: preamble, SFD, payload and optional CRC-32 FCS serialised
// as dibits at 100 Mb/s (one per clock) or 10 Mb/s (one per ten clocks), then the IPG.
module rmii_tx_framer #(
   parameter int PREAMBLE_BYTES = 7,
   parameter int IPG_BYTES      = 12,
   parameter bit GEN_FCS        = 1'b1
) (
   input  logic       rmii_osc,
   input  logic       rst,
   input  logic       speed_10,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic [1:0] rmii_tx,
   output logic       rmii_tx_en,
   output logic       busy,
   output logic       underrun
);

   typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, FCS, IPG} state_t;

   localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_BYTES * 4 - 1);
   localparam logic [15:0] IPG_LAST = 16'(IPG_BYTES * 4 - 1);
   localparam logic [31:0] CRC_POLY = 32'hEDB88320;

   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  div_q, div_d;
   logic        speed_q, speed_d;
   logic [31:0] sh_q, sh_d;
   logic        last_q, last_d;
   logic [31:0] crc_q, crc_d;
   logic [1:0]  tx_q, tx_d;
   logic        tx_en_q, tx_en_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;
   logic        underrun_q, underrun_d;
   logic        tick, tick_next, take, to_ipg;

   always_comb begin
      // NOTE: every variable gets a default before the case so no latch can be inferred.
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      speed_d    = speed_q;
      sh_d       = sh_q;
      last_d     = last_q;
      crc_d      = crc_q;
      tx_d       = tx_q;
      tx_en_d    = tx_en_q;
      underrun_d = 1'b0;
      take       = 1'b0;
      to_ipg     = 1'b0;
      tick       = !speed_q || (div_q == 4'd9);

      if (state_q != IDLE) begin
         div_d = (speed_q && (div_q != 4'd9)) ? div_q + 4'd1 : 4'd0;
      end

      case (state_q)
         IDLE: begin
            // Leaving IDLE is itself a tick: the first preamble dibit goes out now.
            if (tx_valid) begin
               state_d = PRE;
               speed_d = speed_10;
               div_d   = 4'd0;
               cnt_d   = 16'd0;
               crc_d   = 32'hFFFFFFFF;
               tx_d    = 2'b01;
               tx_en_d = 1'b1;
            end
         end
         PRE: begin
            if (tick) begin
               if (cnt_q == PRE_LAST) begin
                  state_d = SFD;
                  cnt_d   = 16'd0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         SFD: begin
            if (tick) begin
               if (cnt_q == 16'd3) begin
                  take = 1'b1;
               end else begin
                  cnt_d = cnt_q + 16'd1;
                  tx_d  = (cnt_q == 16'd2) ? 2'b11 : 2'b01;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (cnt_q != 16'd3) begin
                  cnt_d = cnt_q + 16'd1;
                  tx_d  = sh_q[1:0];
                  sh_d  = sh_q >> 2;
               end else if (!last_q) begin
                  take = 1'b1;
               end else if (GEN_FCS) begin
                  state_d = FCS;
                  cnt_d   = 16'd0;
                  tx_d    = ~crc_q[1:0];
                  sh_d    = ~crc_q >> 2;
               end else begin
                  to_ipg = 1'b1;
               end
            end
         end
         FCS: begin
            if (tick) begin
               if (cnt_q == 16'd15) begin
                  to_ipg = 1'b1;
               end else begin
                  cnt_d = cnt_q + 16'd1;
                  tx_d  = sh_q[1:0];
                  sh_d  = sh_q >> 2;
               end
            end
         end
         IPG: begin
            if (tick) begin
               if (cnt_q == IPG_LAST) begin
                  state_d = IDLE;
                  cnt_d   = 16'd0;
                  div_d   = 4'd0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A byte boundary with tx_ready up either loads the next byte or aborts the frame.
      if (take) begin
         if (tx_valid) begin
            state_d = DATA;
            cnt_d   = 16'd0;
            tx_d    = tx_data[1:0];
            sh_d    = {26'h0, tx_data[7:2]};
            last_d  = tx_last;
            crc_d   = crc32_byte(crc_q, tx_data);
         end else begin
            to_ipg     = 1'b1;
            underrun_d = 1'b1;
         end
      end

      if (to_ipg) begin
         state_d = IPG;
         cnt_d   = 16'd0;
         tx_d    = 2'b00;
         tx_en_d = 1'b0;
      end

      // tx_ready is registered, so it is predicted for the cycle that will carry the 4th tick.
      tick_next = !speed_d || (div_d == 4'd9);
      ready_d   = tick_next && (cnt_d == 16'd3) &&
                  ((state_d == SFD) || ((state_d == DATA) && !last_d));
      busy_d    = (state_d != IDLE);
   end

   always_ff @(posedge rmii_osc) begin
      // NOTE: non-blocking assignments only, so every register sees pre-edge values.
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 16'd0;
         div_q      <= 4'd0;
         speed_q    <= 1'b0;
         sh_q       <= 32'd0;
         last_q     <= 1'b0;
         crc_q      <= 32'hFFFFFFFF;
         tx_q       <= 2'b00;
         tx_en_q    <= 1'b0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         speed_q    <= speed_d;
         sh_q       <= sh_d;
         last_q     <= last_d;
         crc_q      <= crc_d;
         tx_q       <= tx_d;
         tx_en_q    <= tx_en_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         underrun_q <= underrun_d;
      end
   end

   assign tx_ready   = ready_q;
   assign rmii_tx    = tx_q;
   assign rmii_tx_en = tx_en_q;
   assign busy       = busy_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_rmii_tx_framer.sv
// Scoreboard bench for rmii_tx_framer: a default instance and a short-preamble, no-FCS
// instance; expected per-cycle dibits are queued with the stimulus and popped on the wire.
module tb_rmii_tx_framer;

   localparam int MARK = 4;

   logic       rmii_osc = 1'b0;
   logic       rst;
   logic       speed0;
   logic       speed1;
   logic [7:0] tx_data    [2];
   logic       tx_valid   [2];
   logic       tx_last    [2];
   logic       tx_ready   [2];
   logic [1:0] rmii_tx    [2];
   logic       rmii_tx_en [2];
   logic       busy       [2];
   logic       underrun   [2];

   int         n_checks = 0;
   int         n_err    = 0;
   logic [7:0] drv_data [2][$];
   bit         drv_last [2][$];
   int         exp_q    [2][$];
   int         ready_cnt[2];
   int         urun_cnt [2];
   int         last_gap [2];
   logic [7:0] pay[$];

   always #10 rmii_osc = ~rmii_osc;

   rmii_tx_framer u_dut0 (
      .rmii_osc  (rmii_osc),
      .rst       (rst),
      .speed_10  (speed0),
      .tx_data   (tx_data[0]),
      .tx_valid  (tx_valid[0]),
      .tx_last   (tx_last[0]),
      .tx_ready  (tx_ready[0]),
      .rmii_tx   (rmii_tx[0]),
      .rmii_tx_en(rmii_tx_en[0]),
      .busy      (busy[0]),
      .underrun  (underrun[0])
   );

   rmii_tx_framer #(.PREAMBLE_BYTES(2), .IPG_BYTES(12), .GEN_FCS(1'b0)) u_dut1 (
      .rmii_osc  (rmii_osc),
      .rst       (rst),
      .speed_10  (speed1),
      .tx_data   (tx_data[1]),
      .tx_valid  (tx_valid[1]),
      .tx_last   (tx_last[1]),
      .tx_ready  (tx_ready[1]),
      .rmii_tx   (rmii_tx[1]),
      .rmii_tx_en(rmii_tx_en[1]),
      .busy      (busy[1]),
      .underrun  (underrun[1])
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   task automatic push_dib(input int d, input int v, input int rep);
      for (int r = 0; r < rep; r++) exp_q[d].push_back(v);
   endtask

   // Queue bytes for the MAC driver and the dibits expected on the wire. Delivering fewer
   // bytes than pay holds aborts the frame; a non-zero fcs_fix overrides the CRC model.
   task automatic queue_frame(input int d, input int n_deliver, input bit spd,
                              input logic [31:0] fcs_fix);
      int          rep;
      logic [31:0] crc;
      logic [31:0] f;
      bit          full;
      rep  = spd ? 10 : 1;
      crc  = 32'hFFFFFFFF;
      full = (n_deliver == pay.size());
      for (int i = 0; i < (d == 0 ? 7 : 2) * 4; i++) push_dib(d, 1, rep);
      push_dib(d, 1, rep); push_dib(d, 1, rep); push_dib(d, 1, rep); push_dib(d, 3, rep);
      for (int i = 0; i < n_deliver; i++) begin
         for (int k = 0; k < 4; k++) push_dib(d, int'((pay[i] >> (2 * k)) & 8'h3), rep);
         crc = crc_upd(crc, pay[i]);
         drv_data[d].push_back(pay[i]);
         drv_last[d].push_back(full && (i == n_deliver - 1));
      end
      if (full && d == 0) begin
         f = (fcs_fix != 32'h0) ? fcs_fix : ~crc;
         for (int k = 0; k < 16; k++) push_dib(d, int'((f >> (2 * k)) & 32'h3), rep);
      end
      exp_q[d].push_back(MARK);
   endtask

   task automatic wait_done(input int d, input int budget);
      bit done;
      done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         @(negedge rmii_osc);
         if (exp_q[d].size() == 0 && !busy[d] && drv_data[d].size() == 0) done = 1'b1;
      end
      if (!done) check("timeout", 0, 1);
   endtask

   task automatic rand_pay(input int n);
      pay = {};
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
   endtask

   // MAC driver and wire monitor for both instances.
   initial begin
      bit acc[2];
      bit prev_en[2];
      int gap_cnt[2];
      int e;
      int rem;
      for (int d = 0; d < 2; d++) begin
         tx_valid[d] = 1'b0; tx_data[d] = 8'h0; tx_last[d] = 1'b0;
         acc[d] = 1'b0; prev_en[d] = 1'b0; gap_cnt[d] = 0;
         ready_cnt[d] = 0; urun_cnt[d] = 0; last_gap[d] = 0;
      end
      forever begin
         @(negedge rmii_osc);
         for (int d = 0; d < 2; d++) begin
            acc[d] = tx_ready[d] && tx_valid[d] && !rst;
            if (!rst) begin
               if (rmii_tx_en[d]) begin
                  if (!prev_en[d]) last_gap[d] = gap_cnt[d];
                  if (exp_q[d].size() == 0) begin
                     check("dibit_overrun", int'(rmii_tx[d]), MARK);
                  end else begin
                     e = exp_q[d].pop_front();
                     check("tx_dibit", int'(rmii_tx[d]), e);
                  end
               end else begin
                  if (prev_en[d]) begin
                     rem = 0;
                     while (exp_q[d].size() > 0 && exp_q[d][0] != MARK) begin
                        void'(exp_q[d].pop_front());
                        rem++;
                     end
                     if (exp_q[d].size() > 0) void'(exp_q[d].pop_front());
                     check("early_end_missing", rem, 0);
                     gap_cnt[d] = 0;
                  end
                  gap_cnt[d]++;
                  check("idle_dibit", int'(rmii_tx[d]), 0);
               end
               ready_cnt[d] += int'(tx_ready[d]);
               urun_cnt[d]  += int'(underrun[d]);
            end
            prev_en[d] = rmii_tx_en[d];
         end
         @(posedge rmii_osc);
         #1;
         for (int d = 0; d < 2; d++) begin
            if (acc[d] && drv_data[d].size() > 0) begin
               void'(drv_data[d].pop_front());
               void'(drv_last[d].pop_front());
            end
            if (drv_data[d].size() > 0) begin
               tx_valid[d] = 1'b1; tx_data[d] = drv_data[d][0]; tx_last[d] = drv_last[d][0];
            end else begin
               tx_valid[d] = 1'b0; tx_data[d] = 8'h0; tx_last[d] = 1'b0;
            end
         end
      end
   end

   initial begin
      int  r0;
      int  u0;
      bit  seen;
      rst    = 1'b1;
      speed0 = 1'b0;
      speed1 = 1'b0;
      repeat (3) @(posedge rmii_osc);
      @(negedge rmii_osc);
      for (int d = 0; d < 2; d++) begin
         check("rst_tx_en", int'(rmii_tx_en[d]), 0);
         check("rst_tx", int'(rmii_tx[d]), 0);
         check("rst_ready", int'(tx_ready[d]), 0);
         check("rst_busy", int'(busy[d]), 0);
         check("rst_underrun", int'(underrun[d]), 0);
      end
      @(posedge rmii_osc); #1 rst = 1'b0;

      // "123456789" with the known FCS, then a back-to-back frame
      pay = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      queue_frame(0, 9, 1'b0, 32'hCBF43926);
      pay = {8'h00, 8'hFF, 8'h5A};
      queue_frame(0, 3, 1'b0, 32'h0);
      wait_done(0, 3000);
      check("b2b_gap", last_gap[0], 49);
      check("no_underrun", urun_cnt[0], 0);

      // 10 Mb/s single byte; a speed change mid-frame must not take effect
      speed0 = 1'b1;
      r0 = ready_cnt[0];
      pay = {8'hA5};
      queue_frame(0, 1, 1'b1, 32'h0);
      repeat (200) @(negedge rmii_osc);
      speed0 = 1'b0;
      wait_done(0, 3000);
      check("ready_10m", ready_cnt[0] - r0, 1);

      // Underrun after the third byte
      u0 = urun_cnt[0];
      rand_pay(6);
      queue_frame(0, 3, 1'b0, 32'h0);
      wait_done(0, 3000);
      check("underrun_pulses", urun_cnt[0] - u0, 1);

      // Reset in the middle of DATA, then an immediate new frame
      rand_pay(10);
      queue_frame(0, 10, 1'b0, 32'h0);
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge rmii_osc);
         seen = rmii_tx_en[0];
      end
      check("frame_started", int'(seen), 1);
      repeat (40) @(negedge rmii_osc);
      @(posedge rmii_osc); #1;
      rst = 1'b1;
      drv_data[0].delete();
      drv_last[0].delete();
      exp_q[0].delete();
      exp_q[0].push_back(MARK);
      @(posedge rmii_osc); #1;
      rst = 1'b0;
      pay = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      queue_frame(0, 9, 1'b0, 32'hCBF43926);
      @(negedge rmii_osc);
      check("post_rst_tx_en", int'(rmii_tx_en[0]), 0);
      check("post_rst_busy", int'(busy[0]), 0);
      wait_done(0, 3000);

      // Short preamble, no FCS: back-to-back 3-byte and 1-byte frames
      pay = {8'h12, 8'h34, 8'hC3};
      queue_frame(1, 3, 1'b0, 32'h0);
      pay = {8'h7E};
      queue_frame(1, 1, 1'b0, 32'h0);
      wait_done(1, 3000);
      check("nofcs_gap", last_gap[1], 49);
      check("nofcs_underrun", urun_cnt[1], 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
